// File: rtl/sw_input_port.sv
// sw_input_port: synchronized, debounced switch input with sticky
// rising-edge capture and a saturating rising-event counter.
module sw_input_port #(
    parameter int N               = 9,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CW              = 5
) (
    input  logic         Clock,
    input  logic         Resetn,
    input  logic [N-1:0] SW,
    input  logic         cs,
    input  logic         W,
    input  logic [1:0]   ADDR,
    input  logic [15:0]  DOUT,
    output logic [15:0]  Q,
    output logic         Edge_any
);

    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [N-1:0]         sync_a;
    logic [N-1:0]         sync_b;
    logic [N-1:0]         level;
    logic [N-1:0]         level_nxt;
    logic [N-1:0]         edge_r;
    logic [N-1:0]         edge_nxt;
    logic [N-1:0]         rise;
    logic [N-1:0]         clr_mask;
    logic [N-1:0][CW-1:0] cnt;
    logic [N-1:0][CW-1:0] cnt_nxt;
    logic [15:0]          count;
    logic [15:0]          count_nxt;
    logic                 wr_edge;
    logic                 wr_count;

    generate
        if (N < 16) begin : g_pad
            logic unused_dout;
            assign unused_dout = ^DOUT[15:N];
        end
    endgenerate

    assign wr_edge  = cs & W & (ADDR == 2'd1);
    assign wr_count = cs & W & (ADDR == 2'd2);

    always_comb begin
        level_nxt = level;
        cnt_nxt   = cnt;
        for (int i = 0; i < N; i++) begin
            if (sync_b[i] == level[i]) begin
                cnt_nxt[i] = '0;
            end else if (cnt[i] == LAST) begin
                level_nxt[i] = sync_b[i];
                cnt_nxt[i]   = '0;
            end else begin
                cnt_nxt[i] = cnt[i] + CW'(1);
            end
        end
    end

    assign rise = level_nxt & ~level;

    // a new rise on a bit beats a same-cycle clear of that bit
    always_comb begin
        clr_mask = wr_edge ? DOUT[N-1:0] : '0;
        edge_nxt = (edge_r & ~clr_mask) | rise;
    end

    always_comb begin
        count_nxt = count;
        if (|rise) begin
            if (wr_count)
                count_nxt = 16'd1;
            else if (count != 16'hFFFF)
                count_nxt = count + 16'd1;
        end else if (wr_count) begin
            count_nxt = '0;
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            sync_a <= '0;
            sync_b <= '0;
            cnt    <= '0;
            level  <= '0;
            edge_r <= '0;
            count  <= '0;
        end else begin
            sync_a <= SW;
            sync_b <= sync_a;
            cnt    <= cnt_nxt;
            level  <= level_nxt;
            edge_r <= edge_nxt;
            count  <= count_nxt;
        end
    end

    always_comb begin
        Q = '0;
        unique case (ADDR)
            2'd0:    Q[N-1:0] = level;
            2'd1:    Q[N-1:0] = edge_r;
            2'd2:    Q        = count;
            default: Q        = '0;
        endcase
    end

    assign Edge_any = |edge_r;

endmodule

// File: tb/tb_sw_input_port.sv
// tb_sw_input_port: scoreboard bench for sw_input_port with a
// short debounce window.
module tb_sw_input_port;

    logic        Clock;
    logic        Resetn;
    logic [8:0]  SW;
    logic        cs;
    logic        W;
    logic [1:0]  ADDR;
    logic [15:0] DOUT;
    logic [15:0] Q;
    logic        Edge_any;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        int          sel;
        logic [15:0] val;
    } exp_t;

    exp_t sb[$];

    sw_input_port #(
        .N(9),
        .DEBOUNCE_CYCLES(4),
        .CW(3)
    ) dut (
        .Clock(Clock),
        .Resetn(Resetn),
        .SW(SW),
        .cs(cs),
        .W(W),
        .ADDR(ADDR),
        .DOUT(DOUT),
        .Q(Q),
        .Edge_any(Edge_any)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    initial begin
        #1500000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [15:0] obs,
                            input logic [15:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic expect_rd(input string tag, input int sel,
                             input logic [15:0] val);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.val = val;
        sb.push_back(e);
    endtask

    // sel 0..3 = register offset, sel 4 = Edge_any
    task automatic drain();
        exp_t e;
        logic [15:0] obs;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.sel < 4) ADDR = 2'(e.sel);
            #1;
            obs = (e.sel == 4) ? {15'd0, Edge_any} : Q;
            check_eq(e.tag, obs, e.val);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge Clock);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [15:0] d);
        cs = 1'b1;
        W = 1'b1;
        ADDR = a;
        DOUT = d;
        @(posedge Clock);
        #1;
        cs = 1'b0;
        W = 1'b0;
        DOUT = '0;
    endtask

    task automatic do_reset(input logic [8:0] sw0);
        cs = 1'b0;
        W = 1'b0;
        Resetn = 1'b0;
        SW = sw0;
        tick(2);
        Resetn = 1'b1;
    endtask

    logic [7:0] sw_v;
    logic       reached;
    int         cyc;

    initial begin
        Resetn = 1'b0;
        SW = '0;
        cs = 1'b0;
        W = 1'b0;
        ADDR = '0;
        DOUT = '0;
        #1;
        expect_rd("rst_lvl", 0, 16'h0);
        expect_rd("rst_edge", 1, 16'h0);
        expect_rd("rst_cnt", 2, 16'h0);
        expect_rd("rst_any", 4, 16'h0);
        drain();

        // basic latency: level appears at the 6th edge
        do_reset(9'h000);
        SW = 9'h001;
        for (int e = 1; e <= 6; e++) begin
            tick(1);
            expect_rd($sformatf("lat_e%0d", e), 0,
                      (e == 6) ? 16'h001 : 16'h000);
            drain();
        end
        expect_rd("lat_edge", 1, 16'h001);
        expect_rd("lat_cnt", 2, 16'd1);
        expect_rd("lat_any", 4, 16'h1);
        drain();

        // glitches one cycle shorter than the window
        do_reset(9'h000);
        repeat (5) begin
            SW = 9'h008;
            tick(3);
            SW = 9'h000;
            tick(3);
        end
        tick(6);
        expect_rd("gl_lvl", 0, 16'h0);
        expect_rd("gl_edge", 1, 16'h0);
        expect_rd("gl_cnt", 2, 16'h0);
        expect_rd("gl_any", 4, 16'h0);
        drain();

        // write-1-to-clear and set-wins
        do_reset(9'h000);
        SW = 9'h0C1;
        tick(8);
        expect_rd("w1c_edge0", 1, 16'h0C1);
        expect_rd("w1c_cnt0", 2, 16'd1);
        drain();
        wr(2'd1, 16'h0041);
        expect_rd("w1c_edge1", 1, 16'h080);
        expect_rd("w1c_any1", 4, 16'h1);
        drain();
        SW = 9'h041;
        tick(8);
        expect_rd("w1c_lvl2", 0, 16'h041);
        expect_rd("w1c_fall", 1, 16'h080);
        drain();
        wr(2'd1, 16'h0080);
        expect_rd("w1c_clr", 1, 16'h000);
        expect_rd("w1c_any0", 4, 16'h0);
        drain();
        SW = 9'h0C1;
        tick(5);
        wr(2'd1, 16'h0080);
        expect_rd("w1c_setwin", 1, 16'h080);
        expect_rd("w1c_cnt2", 2, 16'd2);
        drain();

        // counter, clear vs increment
        do_reset(9'h000);
        repeat (3) begin
            SW = 9'h001;
            tick(8);
            SW = 9'h000;
            tick(8);
        end
        expect_rd("cnt3", 2, 16'd3);
        drain();
        SW = 9'h001;
        tick(5);
        wr(2'd2, 16'h1234);
        expect_rd("cnt_clr_inc", 2, 16'd1);
        drain();
        SW = 9'h000;
        tick(8);
        wr(2'd2, 16'h0000);
        expect_rd("cnt_clr", 2, 16'd0);
        drain();

        // saturation: staggered bits give one rise per edge
        do_reset(9'h000);
        ADDR = 2'd2;
        reached = 1'b0;
        cyc = 0;
        while (cyc < 70000 && !reached) begin
            for (int i = 0; i < 8; i++)
                sw_v[i] = (((cyc + 8 - i) % 8) < 4);
            SW = {1'b0, sw_v};
            tick(1);
            cyc++;
            if (Q == 16'hFFFF) reached = 1'b1;
        end
        check_eq("sat_reach", {15'd0, reached}, 16'h1);
        repeat (200) begin
            for (int i = 0; i < 8; i++)
                sw_v[i] = (((cyc + 8 - i) % 8) < 4);
            SW = {1'b0, sw_v};
            tick(1);
            cyc++;
        end
        expect_rd("sat_hold", 2, 16'hFFFF);
        drain();

        // all bits rise together
        do_reset(9'h000);
        SW = 9'h1FF;
        tick(8);
        expect_rd("all_lvl", 0, 16'h1FF);
        expect_rd("all_edge", 1, 16'h1FF);
        expect_rd("all_cnt", 2, 16'd1);
        expect_rd("all_any", 4, 16'h1);
        drain();
        SW = 9'h000;
        tick(8);
        expect_rd("all_fall_lvl", 0, 16'h000);
        expect_rd("all_fall_edge", 1, 16'h1FF);
        expect_rd("all_fall_cnt", 2, 16'd1);
        drain();

        // reset mid-debounce
        do_reset(9'h000);
        SW = 9'h010;
        tick(3);
        Resetn = 1'b0;
        #1;
        expect_rd("mid_lvl", 0, 16'h0);
        expect_rd("mid_edge", 1, 16'h0);
        expect_rd("mid_cnt", 2, 16'h0);
        expect_rd("mid_any", 4, 16'h0);
        drain();
        tick(2);
        expect_rd("mid_hold", 0, 16'h0);
        drain();
        Resetn = 1'b1;
        tick(5);
        expect_rd("mid_e5", 0, 16'h000);
        drain();
        tick(1);
        expect_rd("mid_e6", 0, 16'h010);
        drain();
        wr(2'd0, 16'hFFFF);
        wr(2'd3, 16'hFFFF);
        cs = 1'b0;
        W = 1'b1;
        ADDR = 2'd1;
        DOUT = 16'hFFFF;
        tick(1);
        cs = 1'b1;
        W = 1'b0;
        ADDR = 2'd2;
        tick(1);
        cs = 1'b0;
        DOUT = '0;
        expect_rd("ro_lvl", 0, 16'h010);
        expect_rd("ro_edge", 1, 16'h010);
        expect_rd("ro_cnt", 2, 16'd1);
        expect_rd("ro_off3", 3, 16'h0);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
